// File: rtl/byte_lane_ram.sv
// byte_lane_ram
// Byte-addressable single-port data RAM with a request/ready handshake.
// A request is accepted in IDLE, optionally delayed by WAIT_STATES cycles,
// and answered with a one-cycle ready strobe. Transfers of 1, 2 or 4 bytes
// (up to NB bytes) are checked for alignment, size and range; a failing
// transfer does not touch memory, returns rdata = 0 and raises err.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - synchronous active-high reset (memory contents are kept)
//   req    - transfer request, sampled only in IDLE
//   wr_en  - 1 = write, 0 = read, sampled with req
//   addr   - byte address, sampled with req
//   size   - log2 of transfer size in bytes, sampled with req
//   wdata  - lane-aligned write data (byte k on bits 8k+7:8k)
//   rdata  - registered read data, full aligned word containing addr
//   ready  - one-cycle response strobe
//   err    - error flag, meaningful while ready = 1
//
// Assumes DATA_W >= 16 and DEPTH_BYTES > NB so that lane and word index
// fields are both non-empty.
module byte_lane_ram #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr_en,
    input  logic [31:0]       addr,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err
);

    localparam int NB    = DATA_W / 8;
    localparam int LB    = $clog2(NB);
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / NB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    // Transfer currently being decided. With no wait states the memory
    // access happens on the same edge that accepts the request, so the
    // live inputs are used in IDLE and the latched copy afterwards.
    logic              cur_wr;
    logic [31:0]       cur_addr;
    logic [1:0]        cur_size;
    logic [DATA_W-1:0] cur_wdata;

    logic [4:0]        nbytes;
    logic              misaligned;
    logic              size_bad;
    logic              range_bad;
    logic              acc_err;
    logic [32:0]       end_addr;
    logic              enter_resp;
    logic              do_write;
    logic              do_read;
    logic              clr_rdata;
    logic [AW-LB-1:0]  word_idx;
    logic [LB-1:0]     lane_off;
    logic [NB-1:0]     be;

    always_comb begin
        cur_wr    = wr_q;
        cur_addr  = addr_q;
        cur_size  = size_q;
        cur_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            cur_wr    = wr_en;
            cur_addr  = addr;
            cur_size  = size;
            cur_wdata = wdata;
        end

        nbytes     = 5'd1 << cur_size;
        size_bad   = ({27'd0, nbytes} > 32'(NB));
        misaligned = ((cur_addr & ({27'd0, nbytes} - 32'd1)) != 32'd0);
        // 33-bit sum so that addresses near 2^32 cannot wrap into range;
        // this also rejects any set upper address bit.
        end_addr   = {1'b0, cur_addr} + {28'd0, nbytes};
        range_bad  = (end_addr > 33'(DEPTH_BYTES));
        acc_err    = misaligned | size_bad | range_bad;

        word_idx   = cur_addr[AW-1:LB];
        lane_off   = cur_addr[LB-1:0];

        // A reset on the would-be RESP edge suppresses the access entirely.
        enter_resp = !rst &&
                     (((state_q == S_IDLE) && req && (WAIT_STATES == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == 4'd1)));
        do_write   = enter_resp && cur_wr && !acc_err;
        do_read    = enter_resp && !cur_wr && !acc_err;
        clr_rdata  = enter_resp && acc_err;
    end

    // Per-lane write enables: lanes lane_off .. lane_off+nbytes-1. An
    // accepted transfer is aligned and no wider than NB, so it never
    // crosses a word boundary.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_be
            assign be[gi] = do_write &&
                            ({27'd0, nbytes} + 32'(lane_off) > 32'(gi)) &&
                            (32'(lane_off) <= 32'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = wr_en;
                    addr_d  = addr;
                    size_d  = size;
                    wdata_d = wdata;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_resp) begin
            err_d = acc_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // One byte-wide RAM per lane. The read register sits directly on the
    // RAM output and is cleared on reset or an error response; otherwise it
    // holds until the next successful read.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem [WORDS];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (be[gi]) begin
                    mem[word_idx] <= cur_wdata[8*gi +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (rst || clr_rdata) begin
                    rd_q <= 8'd0;
                end else if (do_read) begin
                    rd_q <= mem[word_idx];
                end
            end

            assign rdata[8*gi +: 8] = rd_q;
        end
    endgenerate

    assign ready = (state_q == S_RESP);
    assign err   = err_q;

endmodule

// File: tb/tb_byte_lane_ram.sv
module tb_byte_lane_ram;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        req_v;
    logic              wr_en;
    logic [31:0]       addr;
    logic [1:0]        size;
    logic [31:0]       wdata;
    logic [2:0][31:0]  rdata_v;
    logic [2:0]        ready_v;
    logic [2:0]        err_v;

    int checks   = 0;
    int failures = 0;
    int ws [3] = '{0, 2, 3};

    always #5 clk = ~clk;

    byte_lane_ram #(.DATA_W(32), .DEPTH_BYTES(1024), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .req(req_v[0]), .wr_en(wr_en), .addr(addr),
        .size(size), .wdata(wdata), .rdata(rdata_v[0]), .ready(ready_v[0]),
        .err(err_v[0]));
    byte_lane_ram #(.DATA_W(32), .DEPTH_BYTES(1024), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .req(req_v[1]), .wr_en(wr_en), .addr(addr),
        .size(size), .wdata(wdata), .rdata(rdata_v[1]), .ready(ready_v[1]),
        .err(err_v[1]));
    byte_lane_ram #(.DATA_W(32), .DEPTH_BYTES(1024), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .req(req_v[2]), .wr_en(wr_en), .addr(addr),
        .size(size), .wdata(wdata), .rdata(rdata_v[2]), .ready(ready_v[2]),
        .err(err_v[2]));

    // Reference model: a plain byte array per instance plus a "known" flag,
    // since RAM contents are undefined until written.
    logic [7:0]  ref_mem   [3][1024];
    bit          ref_known [3][1024];
    logic [31:0] exp_rd    [3];
    logic [3:0]  exp_known [3];

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [1:0]  sz;
        logic [31:0] wd;
        logic        e;
        logic [31:0] rd;
        logic        chk;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_xfer(input int inst, input logic w, input logic [31:0] a,
                              input logic [1:0] sz, input logic [31:0] wd,
                              output logic e);
        longint nb;
        longint base;
        nb = longint'(1) << sz;
        e = ((longint'(a) % nb) != 0) || (nb > 4) || (longint'(a) + nb > 1024);
        if (e) begin
            exp_rd[inst]    = 32'd0;
            exp_known[inst] = 4'hF;
        end else if (w) begin
            for (longint b = 0; b < nb; b++) begin
                ref_mem[inst][a + b]   = wd[8 * ((a + b) % 4) +: 8];
                ref_known[inst][a + b] = 1'b1;
            end
        end else begin
            base = longint'(a) - (longint'(a) % 4);
            for (int k = 0; k < 4; k++) begin
                exp_rd[inst][8*k +: 8] = ref_mem[inst][base + k];
                exp_known[inst][k]     = ref_known[inst][base + k];
            end
        end
    endtask

    task automatic xfer(input int inst, input logic w, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        wr_en = w; addr = a; size = sz; wdata = wd;
        req_v[inst] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_v = 3'b000;
        lat = 1;
        while (!ready_v[inst] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = rdata_v[inst];
        e  = err_v[inst];
        @(negedge clk);
        chk("ready_single_cycle", {31'd0, ready_v[inst]}, 32'd0);
    endtask

    task automatic run_one(input int inst, input logic w, input logic [31:0] a,
                           input logic [1:0] sz, input logic [31:0] wd,
                           output logic [31:0] rd, output logic e);
        logic exp_e;
        int   lat;
        logic [31:0] m;
        model_xfer(inst, w, a, sz, wd, exp_e);
        xfer(inst, w, a, sz, wd, rd, e, lat);
        $display("xfer inst=%0d %s addr=%h size=%0d wdata=%h -> rdata=%h err=%0d lat=%0d",
                 inst, w ? "W" : "R", a, sz, wd, rd, e, lat);
        chk("latency", lat, 1 + ws[inst]);
        chk("err", {31'd0, e}, {31'd0, exp_e});
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{exp_known[inst][k]}};
        if (m != 32'd0) chk("rdata_model", rd & m, exp_rd[inst] & m);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          pulses;
        int          mode;
        int          inst;
        logic [31:0] a;

        for (int i = 0; i < 3; i++) begin
            exp_rd[i] = 32'd0;
            exp_known[i] = 4'hF;
            for (int j = 0; j < 1024; j++) begin
                ref_mem[i][j] = 8'd0;
                ref_known[i][j] = 1'b0;
            end
        end

        vt[0]  = '{1'b1, 32'h10,       2'd2, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 32'h10,       2'd2, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
        vt[2]  = '{1'b1, 32'h20,       2'd2, 32'h11223344, 1'b0, 32'h0,        1'b0};
        vt[3]  = '{1'b1, 32'h22,       2'd0, 32'h00AA0000, 1'b0, 32'h0,        1'b0};
        vt[4]  = '{1'b0, 32'h20,       2'd2, 32'h0,        1'b0, 32'h11AA3344, 1'b1};
        vt[5]  = '{1'b1, 32'h30,       2'd2, 32'h00000000, 1'b0, 32'h0,        1'b0};
        vt[6]  = '{1'b1, 32'h32,       2'd1, 32'hBEEF0000, 1'b0, 32'h0,        1'b0};
        vt[7]  = '{1'b0, 32'h30,       2'd2, 32'h0,        1'b0, 32'hBEEF0000, 1'b1};
        vt[8]  = '{1'b1, 32'h31,       2'd1, 32'h12345678, 1'b1, 32'h0,        1'b1};
        vt[9]  = '{1'b0, 32'h30,       2'd2, 32'h0,        1'b0, 32'hBEEF0000, 1'b1};
        vt[10] = '{1'b1, 32'h3FC,      2'd2, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
        vt[11] = '{1'b0, 32'h3FE,      2'd1, 32'h0,        1'b0, 32'hCAFEF00D, 1'b1};
        vt[12] = '{1'b0, 32'h400,      2'd2, 32'h0,        1'b1, 32'h0,        1'b1};
        vt[13] = '{1'b1, 32'h400,      2'd2, 32'h55555555, 1'b1, 32'h0,        1'b1};
        vt[14] = '{1'b0, 32'h80000000, 2'd2, 32'h0,        1'b1, 32'h0,        1'b1};
        vt[15] = '{1'b0, 32'h3F8,      2'd3, 32'h0,        1'b1, 32'h0,        1'b1};

        rst = 1'b1; req_v = 3'b000; wr_en = 1'b0; addr = 32'd0; size = 2'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("reset_ready", {31'd0, ready_v[i]}, 32'd0);
            chk("reset_err",   {31'd0, err_v[i]},   32'd0);
            chk("reset_rdata", rdata_v[i],          32'd0);
        end

        // Directed vectors, no wait states.
        for (int i = 0; i < 16; i++) begin
            run_one(0, vt[i].w, vt[i].a, vt[i].sz, vt[i].wd, rd, e);
            chk("vec_err", {31'd0, e}, {31'd0, vt[i].e});
            if (vt[i].chk) chk("vec_rdata", rd, vt[i].rd);
        end

        // Two wait states: latency is checked inside run_one.
        run_one(1, 1'b1, 32'h10, 2'd2, 32'hA5A5_0F0F, rd, e);
        run_one(1, 1'b0, 32'h10, 2'd2, 32'h0, rd, e);

        // req held high: accepts every 4 cycles, ready pulses at offsets 2,6,10,14.
        @(negedge clk);
        wr_en = 1'b0; addr = 32'h10; size = 2'd2; req_v[1] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ready_v[1] !== ((i % 4) == 2)) pulses++;
        end
        req_v = 3'b000;
        $display("held_req inst=1 pattern_errors=%0d", pulses);
        chk("held_req_pattern", pulses, 0);
        repeat (4) @(negedge clk);
        chk("held_req_rdata", rdata_v[1], 32'hA5A5_0F0F);

        // Reset in the final wait cycle, three wait states.
        run_one(2, 1'b1, 32'h40, 2'd2, 32'h1111_1111, rd, e);
        run_one(2, 1'b0, 32'h40, 2'd2, 32'h0, rd, e);
        @(negedge clk);
        wr_en = 1'b1; addr = 32'h40; size = 2'd0; wdata = 32'h55; req_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_v = 3'b000;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (ready_v[2]) pulses++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", {31'd0, ready_v[2]}, 32'd0);
        chk("midrst_err",   {31'd0, err_v[2]},   32'd0);
        chk("midrst_rdata", rdata_v[2],          32'd0);
        repeat (6) begin
            @(negedge clk);
            if (ready_v[2]) pulses++;
        end
        $display("mid_reset inst=2 stray_ready=%0d", pulses);
        chk("midrst_no_ready", pulses, 0);
        for (int i = 0; i < 3; i++) begin
            exp_rd[i] = 32'd0;
            exp_known[i] = 4'hF;
        end
        run_one(2, 1'b0, 32'h40, 2'd2, 32'h0, rd, e);
        chk("midrst_mem_kept", rd, 32'h1111_1111);

        // Randomised traffic against the model.
        for (int n = 0; n < 150; n++) begin
            inst = $urandom_range(0, 2);
            mode = $urandom_range(0, 9);
            if (mode < 8)       a = 32'($urandom_range(0, 127));
            else if (mode == 8) a = 32'(1020 + $urandom_range(0, 7));
            else                a = $urandom;
            run_one(inst, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                    $urandom, rd, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
